debounce_edge: RTL and testbench

Upstream conditioning stage for the `d_ff` storage cells: it takes one raw, bouncy, asynchronous input (push-button or switch) and produces a clean debounced level, plus single-cycle rise and fall pulses suitable for driving a flip-flop `d`/`en` pair. It also keeps a wrapping count of accepted presses. It contains an optional two-flop synchronizer, a stability counter, and a four-state debounce FSM.

---
 rtl/debounce_edge.sv | 137 +++++++++++++
 tb/tb_debounce_edge.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - debouncer with registered level, rise/fall pulses and press counter.
// Optional two-flop input synchronizer enabled by DEBOUNCE_INPUT_SYNC_EN.
module debounce_edge #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       btn_in,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  logic smp;

`ifdef DEBOUNCE_INPUT_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  assign smp = s2;
`else
  assign smp = btn_in;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             rise_d;
  logic             fall_d;
  logic             inc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      LOW: begin
        if (smp) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      RISE_WAIT: begin
        if (!smp) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          inc     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!smp) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      FALL_WAIT: begin
        if (smp) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // busy follows the next state so it is high exactly while a WAIT state is occupied
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= LOW;
      cnt_q     <= '0;
      level     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      busy      <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
      busy    <= (state_d == RISE_WAIT) || (state_d == FALL_WAIT);
      if (inc) begin
        press_cnt <= press_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - directed vector bench for debounce_edge (STABLE_CYCLES=4).
// Works in both builds; DEBOUNCE_INPUT_SYNC_EN shifts the expected sample stream by two edges.
module tb_debounce_edge;

  localparam int SC = 4;
`ifdef DEBOUNCE_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NV = 32;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       btn_in = 1'b0;
  logic       level;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] press_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(5)) dut (
    .clk       (clk),
    .clear     (clear),
    .btn_in    (btn_in),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .press_cnt (press_cnt)
  );

  typedef struct {
    logic       clr;
    logic       btn;
    logic       lvl;
    logic       rse;
    logic       fal;
    logic       bsy;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl[NV];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic b);
    clear  = c;
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  // Rows are hand-computed for the unsynchronized build; with the synchronizer the
  // FSM sees the same sample stream two edges later, and the clears zero the pipe.
  function automatic vec_t expected(input int i);
    vec_t z;
    z = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    if (LAT == 0) return tbl[i];
    if (i >= 3 + LAT && i < 30) return tbl[i - LAT];
    return z;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   k;

    //          clr   btn   lvl   rise  fall  busy  press_cnt
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // clear held with btn high
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}; // debounce restarts after release
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1}; // release from HIGH
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}; // 3-sample glitch
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // reject in completion cycle
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}; // bounce 1,1,0,1,1,0
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}; // then steady high
    tbl[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[26] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[27] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[28] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[29] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2}; // fall starts, then clear
    tbl[30] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[31] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].clr, tbl[i].btn);
      e = expected(i);
      check($sformatf("v%0d level", i), {7'd0, level}, {7'd0, e.lvl});
      check($sformatf("v%0d rise", i), {7'd0, rise}, {7'd0, e.rse});
      check($sformatf("v%0d fall", i), {7'd0, fall}, {7'd0, e.fal});
      check($sformatf("v%0d busy", i), {7'd0, busy}, {7'd0, e.bsy});
      check($sformatf("v%0d press_cnt", i), press_cnt, e.pc);
    end

    // 256 clean presses: latency, single-cycle pulses, and press_cnt wrap
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int n = 1; n <= 256; n++) begin
      k = 0;
      clear  = 1'b0;
      btn_in = 1'b1;
      do begin
        @(posedge clk);
        #1;
        k++;
      end while (!rise && k < 40);
      if (!rise) check($sformatf("press %0d rise timeout", n), {7'd0, rise}, 8'd1);
      if (n == 1) check("rise latency", 8'(k), 8'(SC + LAT));
      if (n == 255) check("press_cnt after 255", press_cnt, 8'd255);
      if (n == 256) check("press_cnt wrap", press_cnt, 8'd0);
      step(1'b0, 1'b1);
      if (n == 1 || n == 256) check($sformatf("press %0d rise one cycle", n), {7'd0, rise}, 8'd0);

      k = 0;
      btn_in = 1'b0;
      do begin
        @(posedge clk);
        #1;
        k++;
      end while (!fall && k < 40);
      if (!fall) check($sformatf("press %0d fall timeout", n), {7'd0, fall}, 8'd1);
      if (n == 1) begin
        check("fall latency", 8'(k), 8'(SC + LAT));
        check("fall level", {7'd0, level}, 8'd0);
        check("fall press_cnt", press_cnt, 8'd1);
      end
      step(1'b0, 1'b0);
      if (n == 1) check("fall one cycle", {7'd0, fall}, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
